// File: rtl/spi_burst_pkg.sv
// Shared definitions for the SPI flash burst reader: register map, status
// layout, control bit positions and the burst FSM state type.
package spi_burst_pkg;

    localparam logic [1:0] REG_CTRL  = 2'd0;
    localparam logic [1:0] REG_ADDR  = 2'd1;
    localparam logic [1:0] REG_COUNT = 2'd2;
    localparam logic [1:0] REG_DATA  = 2'd3;

    localparam int STAT_BUSY  = 31;
    localparam int STAT_FULL  = 30;
    localparam int STAT_EMPTY = 29;

    localparam int CTRL_TX_ADDR = 8;
    localparam int CTRL_ABORT   = 31;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        LAUNCH = 2'd2,
        WAIT   = 2'd3
    } burst_state_e;

    // First flash byte arrives in [31:24]; reversing puts it in [7:0].
    function automatic logic [31:0] byte_swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/spi_fifo.sv
// Synchronous word FIFO with registered head-of-queue visibility and an
// occupancy count; pushes when full and pops when empty are dropped.
module spi_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (level_q == FULL_LEVEL);
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/spi_burst_reader.sv
// CPU-programmed burst engine: issues one 32-bit read per word to spi_tx,
// steps the flash address by 4 and queues returned words for the CPU.
module spi_burst_reader #(
    parameter int DEPTH = 8,
    parameter int CW    = 8,
    parameter bit SWAP  = 1'b0
) (
    input  logic        wb_clk,
    input  logic        wb_rst_n,
    input  logic        cyc,
    input  logic        we,
    input  logic [1:0]  adr,
    input  logic [31:0] wdat,
    output logic [31:0] rdt,
    output logic [7:0]  code,
    output logic [23:0] addr,
    output logic        tx_addr,
    output logic        no_read,
    output logic        req,
    input  logic [31:0] rdata,
    input  logic        ready
);

    import spi_burst_pkg::*;

    localparam int LW = $clog2(DEPTH) + 1;

    burst_state_e  state_q, state_d;
    logic [7:0]    code_q, code_d;
    logic          tx_addr_q, tx_addr_d;
    logic [23:0]   addr_q, addr_d;
    logic [CW-1:0] count_q, count_d;
    logic          abort_q, abort_d;

    logic          wr_strobe;
    logic          ctrl_wr;
    logic          abort_wr;
    logic          abort_req;
    logic          pop;
    logic          push;
    logic [CW-1:0] count_dec;
    logic [31:0]   push_data;
    logic [31:0]   fifo_head;
    logic [LW-1:0] fifo_level;
    logic          fifo_full;
    logic          fifo_empty;
    logic [31:0]   status;
    logic          unused_wdat;

    assign wr_strobe = cyc && we;
    assign ctrl_wr   = wr_strobe && (adr == REG_CTRL);
    assign abort_wr  = ctrl_wr && wdat[CTRL_ABORT];
    assign abort_req = abort_q || abort_wr;
    assign pop       = cyc && !we && (adr == REG_DATA);
    assign count_dec = count_q - CW'(1);
    assign push_data = SWAP ? byte_swap(rdata) : rdata;
    assign unused_wdat = ^wdat[30:24];

    assign code    = code_q;
    assign addr    = addr_q;
    assign tx_addr = tx_addr_q;
    assign no_read = 1'b0;

    spi_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk_i   (wb_clk),
        .rst_ni  (wb_rst_n),
        .push_i  (push),
        .data_i  (push_data),
        .pop_i   (pop),
        .head_o  (fifo_head),
        .level_o (fifo_level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q   <= IDLE;
            code_q    <= '0;
            tx_addr_q <= 1'b0;
            addr_q    <= '0;
            count_q   <= '0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            tx_addr_q <= tx_addr_d;
            addr_q    <= addr_d;
            count_q   <= count_d;
            abort_q   <= abort_d;
        end
    end

    // Address/count are only writable in IDLE, so they double as the
    // live working copies while a burst runs.
    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        tx_addr_d = tx_addr_q;
        addr_d    = addr_q;
        count_d   = count_q;
        abort_d   = abort_q;
        req       = 1'b0;
        push      = 1'b0;

        case (state_q)
            IDLE: begin
                if (ctrl_wr && !wdat[CTRL_ABORT]) begin
                    code_d    = wdat[7:0];
                    tx_addr_d = wdat[CTRL_TX_ADDR];
                    if (count_q != '0) begin
                        state_d = ISSUE;
                    end
                end
                if (wr_strobe && (adr == REG_ADDR)) begin
                    addr_d = wdat[23:0];
                end
                if (wr_strobe && (adr == REG_COUNT)) begin
                    count_d = wdat[CW-1:0];
                end
            end
            ISSUE: begin
                if (abort_req) begin
                    state_d = IDLE;
                end else if (!fifo_full) begin
                    req     = 1'b1;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (ready) begin
                    push    = 1'b1;
                    addr_d  = addr_q + 24'd4;
                    count_d = count_dec;
                    if ((count_dec != '0) && !abort_req) begin
                        state_d = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if ((state_q != IDLE) && abort_wr) begin
            abort_d = 1'b1;
        end
        if (state_d == IDLE) begin
            abort_d = 1'b0;
        end
    end

    always_comb begin
        status                = '0;
        status[STAT_BUSY]     = (state_q != IDLE);
        status[STAT_FULL]     = fifo_full;
        status[STAT_EMPTY]    = fifo_empty;
        status[LW-1:0]        = fifo_level;

        rdt = '0;
        if (cyc) begin
            case (adr)
                REG_CTRL:  rdt = status;
                REG_ADDR:  rdt = {8'h00, addr_q};
                REG_COUNT: rdt = 32'(count_q);
                default:   rdt = fifo_empty ? 32'h0 : fifo_head;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_burst_reader.sv
// Directed bench for spi_burst_reader: a plain and a byte-swapping instance
// share one bus and one behavioural spi_tx responder.
module tb_spi_burst_reader;

    localparam int SPI_CYCLES = 8;

    logic        wb_clk;
    logic        wb_rst_n;
    logic        cyc;
    logic        we;
    logic [1:0]  adr;
    logic [31:0] wdat;
    logic [31:0] rdata;
    logic        ready;

    logic [31:0] rdt0, rdt1;
    logic [7:0]  code0, code1;
    logic [23:0] addr0, addr1;
    logic        tx_addr0, tx_addr1;
    logic        no_read0, no_read1;
    logic        req0, req1;

    int checks;
    int fails;
    int reqCount;
    logic [23:0] reqAddrLog [64];
    logic [7:0]  reqCodeLog [64];
    logic        reqTxLog   [64];

    spi_burst_reader #(.DEPTH(8), .CW(8), .SWAP(1'b0)) dut (
        .wb_clk (wb_clk), .wb_rst_n (wb_rst_n), .cyc (cyc), .we (we),
        .adr (adr), .wdat (wdat), .rdt (rdt0), .code (code0), .addr (addr0),
        .tx_addr (tx_addr0), .no_read (no_read0), .req (req0),
        .rdata (rdata), .ready (ready)
    );

    spi_burst_reader #(.DEPTH(8), .CW(8), .SWAP(1'b1)) dutSwap (
        .wb_clk (wb_clk), .wb_rst_n (wb_rst_n), .cyc (cyc), .we (we),
        .adr (adr), .wdat (wdat), .rdt (rdt1), .code (code1), .addr (addr1),
        .tx_addr (tx_addr1), .no_read (no_read1), .req (req1),
        .rdata (rdata), .ready (ready)
    );

    initial begin
        wb_clk = 1'b0;
        forever #5 wb_clk = ~wb_clk;
    end

    // Flash contents indexed by the global transaction number.
    function automatic logic [31:0] flashWord(input int i);
        case (i)
            0:       return 32'h11223344;
            1:       return 32'h55667788;
            2:       return 32'h99AABBCC;
            default: return 32'hC0DE0000 + i;
        endcase
    endfunction

    // Behavioural spi_tx: drops ready after req, returns a word later.
    initial begin
        ready    = 1'b1;
        rdata    = '0;
        reqCount = 0;
        forever begin
            @(negedge wb_clk);
            if (req0 === 1'b1) begin
                if (reqCount < 64) begin
                    reqAddrLog[reqCount] = addr0;
                    reqCodeLog[reqCount] = code0;
                    reqTxLog[reqCount]   = tx_addr0;
                end
                reqCount = reqCount + 1;
                @(posedge wb_clk);
                #1 ready = 1'b0;
                repeat (SPI_CYCLES) @(posedge wb_clk);
                #1;
                rdata = flashWord(reqCount - 1);
                ready = 1'b1;
            end
        end
    end

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge wb_clk);
        cyc = 1'b1; we = 1'b1; adr = a; wdat = d;
        @(negedge wb_clk);
        cyc = 1'b0; we = 1'b0; wdat = '0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d0, output logic [31:0] d1);
        @(negedge wb_clk);
        cyc = 1'b1; we = 1'b0; adr = a;
        #1;
        d0 = rdt0;
        d1 = rdt1;
        @(negedge wb_clk);
        cyc = 1'b0;
    endtask

    task automatic wait_idle(input int limit, output bit ok);
        logic [31:0] s0, s1;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            bus_read(2'd0, s0, s1);
            if (!s0[31] && ready) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_reqs(input int target, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge wb_clk);
            #2;
            if (reqCount >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] r0, r1;
        wb_rst_n = 1'b0;
        #1;
        checks++;
        if ({req0, code0, addr0, tx_addr0, no_read0} !== 35'h0) begin
            fails++;
            $display("[TB] FAIL reset_outputs: got %h expected 0", {req0, code0, addr0, tx_addr0, no_read0});
        end
        repeat (2) @(negedge wb_clk);
        wb_rst_n = 1'b1;
        bus_read(2'd0, r0, r1);
        checks++;
        if (r0 !== 32'h20000000) begin
            fails++;
            $display("[TB] FAIL reset_status: got %h expected %h", r0, 32'h20000000);
        end
        bus_read(2'd2, r0, r1);
        checks++;
        if (r0 !== 32'h0) begin
            fails++;
            $display("[TB] FAIL reset_count: got %h expected 0", r0);
        end
    endtask

    task automatic test_basic_burst();
        logic [31:0] r0, r1;
        logic [31:0] expSwap [3];
        bit ok;
        int base;
        expSwap[0] = 32'h44332211;
        expSwap[1] = 32'h88776655;
        expSwap[2] = 32'hCCBBAA99;
        base = reqCount;
        bus_write(2'd1, 32'h00000100);
        bus_write(2'd2, 32'd3);
        bus_write(2'd0, 32'h00000103);
        #1;
        checks++;
        if (req0 !== 1'b1) begin
            fails++;
            $display("[TB] FAIL basic_req_latency: got %b expected 1", req0);
        end
        wait_idle(200, ok);
        checks++;
        if (!ok || (reqCount - base) != 3) begin
            fails++;
            $display("[TB] FAIL basic_req_count: got %0d expected 3 (idle=%0b)", reqCount - base, ok);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (reqAddrLog[base + i] !== 24'h000100 + 24'(4 * i)) begin
                fails++;
                $display("[TB] FAIL basic_req_addr%0d: got %h expected %h", i, reqAddrLog[base + i], 24'h000100 + 24'(4 * i));
            end
        end
        checks++;
        if (reqCodeLog[base] !== 8'h03 || reqTxLog[base] !== 1'b1) begin
            fails++;
            $display("[TB] FAIL basic_code: got %h/%b expected 03/1", reqCodeLog[base], reqTxLog[base]);
        end
        bus_read(2'd0, r0, r1);
        checks++;
        if (r0 !== 32'h00000003) begin
            fails++;
            $display("[TB] FAIL basic_status_full3: got %h expected %h", r0, 32'h00000003);
        end
        for (int i = 0; i < 3; i++) begin
            bus_read(2'd3, r0, r1);
            checks++;
            if (r0 !== flashWord(i)) begin
                fails++;
                $display("[TB] FAIL basic_pop%0d: got %h expected %h", i, r0, flashWord(i));
            end
            checks++;
            if (r1 !== expSwap[i]) begin
                fails++;
                $display("[TB] FAIL swap_pop%0d: got %h expected %h", i, r1, expSwap[i]);
            end
        end
        bus_read(2'd0, r0, r1);
        checks++;
        if (r0 !== 32'h20000000) begin
            fails++;
            $display("[TB] FAIL basic_status_end: got %h expected %h", r0, 32'h20000000);
        end
        bus_read(2'd1, r0, r1);
        checks++;
        if (r0 !== 32'h0000010C) begin
            fails++;
            $display("[TB] FAIL basic_addr_end: got %h expected %h", r0, 32'h0000010C);
        end
    endtask

    task automatic test_count_zero();
        logic [31:0] r0, r1;
        int base;
        bit sawBusy;
        base = reqCount;
        sawBusy = 1'b0;
        bus_write(2'd2, 32'd0);
        bus_write(2'd0, 32'h00000103);
        for (int i = 0; i < 5; i++) begin
            bus_read(2'd0, r0, r1);
            if (r0[31]) sawBusy = 1'b1;
        end
        checks++;
        if ((reqCount - base) != 0 || sawBusy) begin
            fails++;
            $display("[TB] FAIL count_zero: got reqs=%0d busy=%0b expected 0/0", reqCount - base, sawBusy);
        end
    endtask

    task automatic test_fifo_full();
        logic [31:0] r0, r1;
        int base;
        bit ok;
        base = reqCount;
        bus_write(2'd1, 32'h00000200);
        bus_write(2'd2, 32'd12);
        bus_write(2'd0, 32'h00000103);
        wait_reqs(base + 8, 300, ok);
        repeat (40) @(negedge wb_clk);
        checks++;
        if (!ok || (reqCount - base) != 8) begin
            fails++;
            $display("[TB] FAIL full_req_count: got %0d expected 8", reqCount - base);
        end
        bus_read(2'd0, r0, r1);
        checks++;
        if (r0 !== 32'hC0000008) begin
            fails++;
            $display("[TB] FAIL full_status: got %h expected %h", r0, 32'hC0000008);
        end
        bus_read(2'd3, r0, r1);
        checks++;
        if (r0 !== flashWord(base)) begin
            fails++;
            $display("[TB] FAIL full_first_pop: got %h expected %h", r0, flashWord(base));
        end
        repeat (40) @(negedge wb_clk);
        checks++;
        if ((reqCount - base) != 9) begin
            fails++;
            $display("[TB] FAIL full_one_more_req: got %0d expected 9", reqCount - base);
        end
        bus_write(2'd0, 32'h80000000);
        wait_idle(50, ok);
        bus_read(2'd0, r0, r1);
        checks++;
        if (!ok || r0 !== 32'h40000008) begin
            fails++;
            $display("[TB] FAIL full_abort_status: got %h expected %h", r0, 32'h40000008);
        end
        bus_read(2'd1, r0, r1);
        checks++;
        if (r0 !== 32'h00000224) begin
            fails++;
            $display("[TB] FAIL full_addr: got %h expected %h", r0, 32'h00000224);
        end
        bus_read(2'd2, r0, r1);
        checks++;
        if (r0 !== 32'd3) begin
            fails++;
            $display("[TB] FAIL full_count: got %h expected %h", r0, 32'd3);
        end
        for (int i = 1; i <= 8; i++) begin
            bus_read(2'd3, r0, r1);
            checks++;
            if (r0 !== flashWord(base + i)) begin
                fails++;
                $display("[TB] FAIL full_drain%0d: got %h expected %h", i, r0, flashWord(base + i));
            end
        end
    endtask

    task automatic test_abort();
        logic [31:0] r0, r1;
        int base;
        bit ok;
        base = reqCount;
        bus_write(2'd1, 32'h00000300);
        bus_write(2'd2, 32'd5);
        bus_write(2'd0, 32'h00000103);
        wait_reqs(base + 2, 100, ok);
        repeat (2) @(negedge wb_clk);
        bus_write(2'd0, 32'h80000000);
        wait_idle(50, ok);
        repeat (30) @(negedge wb_clk);
        checks++;
        if (!ok || (reqCount - base) != 2) begin
            fails++;
            $display("[TB] FAIL abort_req_count: got %0d expected 2", reqCount - base);
        end
        bus_read(2'd0, r0, r1);
        checks++;
        if (r0 !== 32'h00000002) begin
            fails++;
            $display("[TB] FAIL abort_status: got %h expected %h", r0, 32'h00000002);
        end
        bus_read(2'd2, r0, r1);
        checks++;
        if (r0 !== 32'd3) begin
            fails++;
            $display("[TB] FAIL abort_count: got %h expected %h", r0, 32'd3);
        end
        for (int i = 0; i < 2; i++) begin
            bus_read(2'd3, r0, r1);
            checks++;
            if (r0 !== flashWord(base + i)) begin
                fails++;
                $display("[TB] FAIL abort_pop%0d: got %h expected %h", i, r0, flashWord(base + i));
            end
        end
    endtask

    task automatic test_addr_wrap();
        logic [31:0] r0, r1;
        int base;
        bit ok;
        base = reqCount;
        bus_write(2'd1, 32'h00FFFFFC);
        bus_write(2'd2, 32'd2);
        bus_write(2'd0, 32'h000000AB);
        wait_idle(100, ok);
        checks++;
        if (!ok || (reqCount - base) != 2 || reqAddrLog[base] !== 24'hFFFFFC || reqAddrLog[base + 1] !== 24'h000000) begin
            fails++;
            $display("[TB] FAIL wrap_addr: got %h,%h expected fffffc,000000", reqAddrLog[base], reqAddrLog[base + 1]);
        end
        checks++;
        if (reqCodeLog[base] !== 8'hAB || reqTxLog[base] !== 1'b0) begin
            fails++;
            $display("[TB] FAIL wrap_code: got %h/%b expected ab/0", reqCodeLog[base], reqTxLog[base]);
        end
        bus_read(2'd1, r0, r1);
        checks++;
        if (r0 !== 32'h00000004) begin
            fails++;
            $display("[TB] FAIL wrap_addr_end: got %h expected %h", r0, 32'h00000004);
        end
        bus_read(2'd3, r0, r1);
        bus_read(2'd3, r0, r1);
    endtask

    task automatic test_pop_empty();
        logic [31:0] r0, r1;
        bus_read(2'd3, r0, r1);
        checks++;
        if (r0 !== 32'h0) begin
            fails++;
            $display("[TB] FAIL empty_pop: got %h expected 0", r0);
        end
        bus_read(2'd0, r0, r1);
        checks++;
        if (r0 !== 32'h20000000) begin
            fails++;
            $display("[TB] FAIL empty_status: got %h expected %h", r0, 32'h20000000);
        end
    endtask

    task automatic test_reset_midburst();
        logic [31:0] r0, r1;
        int base;
        bit ok;
        base = reqCount;
        bus_write(2'd1, 32'h00000400);
        bus_write(2'd2, 32'd4);
        bus_write(2'd0, 32'h00000103);
        wait_reqs(base + 2, 100, ok);
        repeat (2) @(negedge wb_clk);
        wb_rst_n = 1'b0;
        #1;
        checks++;
        if (!ok || {req0, code0, addr0, tx_addr0, no_read0} !== 35'h0) begin
            fails++;
            $display("[TB] FAIL midreset_outputs: got %h expected 0", {req0, code0, addr0, tx_addr0, no_read0});
        end
        repeat (3) @(negedge wb_clk);
        wb_rst_n = 1'b1;
        repeat (40) @(negedge wb_clk);
        checks++;
        if ((reqCount - base) != 2) begin
            fails++;
            $display("[TB] FAIL midreset_no_req: got %0d expected 2", reqCount - base);
        end
        bus_read(2'd0, r0, r1);
        checks++;
        if (r0 !== 32'h20000000) begin
            fails++;
            $display("[TB] FAIL midreset_status: got %h expected %h", r0, 32'h20000000);
        end
    endtask

    initial begin
        checks   = 0;
        fails    = 0;
        cyc      = 1'b0;
        we       = 1'b0;
        adr      = 2'd0;
        wdat     = '0;
        wb_rst_n = 1'b0;
        test_reset();
        test_basic_burst();
        test_count_zero();
        test_fifo_full();
        test_abort();
        test_addr_wrap();
        test_pop_empty();
        test_reset_midburst();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
